// File: rtl/block_scheduler.sv
// rtl/block_scheduler.sv - kernel block scheduler feeding NUM_CORES cores round-robin
`timescale 1ns/100ps
module block_scheduler #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_WIDTH          = 16,
  parameter int BID_WIDTH         = 16
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic                                               abort,
  input  logic [TC_WIDTH-1:0]                                thread_count,
  input  logic [NUM_CORES-1:0]                               core_done,
  output logic [NUM_CORES-1:0]                               core_start,
  output logic [NUM_CORES-1:0]                               core_reset,
  output logic [NUM_CORES*BID_WIDTH-1:0]                     core_block_id,
  output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0] core_thread_count,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               aborted,
  output logic [TC_WIDTH-1:0]                                blocks_done
);

  localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int CTW     = LOG_TPB + 1;
  localparam int PW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW      = TC_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [TC_WIDTH-1:0]  tc_q;
  logic [CW-1:0]        total_blocks, dispatched, comp_cnt, bd_next, last_base, launch_blocks;
  logic [CTW-1:0]       last_cnt, grant_ct;
  logic [PW-1:0]        rr_ptr, grant_idx, rr_next, cand_idx;
  logic                 grant_fire;
  logic [NUM_CORES-1:0] completing, run_q;
  logic [BID_WIDTH-1:0] bid_q [NUM_CORES];
  logic [CTW-1:0]       ct_q  [NUM_CORES];

  // Only cores actually running may complete; done from a parked core is ignored.
  assign completing    = core_done & run_q;
  assign launch_blocks = (CW'(thread_count) + CW'(THREADS_PER_BLOCK - 1)) >> LOG_TPB;
  assign last_base     = dispatched << LOG_TPB;
  assign last_cnt      = CTW'(CW'(tc_q) - last_base);
  assign grant_ct      = (dispatched == total_blocks - CW'(1)) ? last_cnt : CTW'(THREADS_PER_BLOCK);

  always_comb begin
    comp_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) comp_cnt = comp_cnt + CW'(completing[i]);
    bd_next = CW'(blocks_done) + comp_cnt;
  end

  // First parked core at or after rr_ptr; a core completing now still reads as running.
  always_comb begin
    grant_fire = 1'b0;
    grant_idx  = '0;
    cand_idx   = '0;
    if (state == S_RUN && !abort && dispatched < total_blocks) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        cand_idx = PW'((int'(rr_ptr) + k) % NUM_CORES);
        if (!grant_fire && !run_q[cand_idx]) begin
          grant_fire = 1'b1;
          grant_idx  = cand_idx;
        end
      end
    end
    rr_next = PW'((int'(grant_idx) + 1) % NUM_CORES);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        if (abort)                          state_nx = S_DRAIN;
        else if (bd_next >= total_blocks)   state_nx = S_DONE;
      end
      S_DRAIN: if ((run_q & ~completing) == '0) state_nx = S_DONE;
      S_DONE:  if (!start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_q         <= '0;
      total_blocks <= '0;
      dispatched   <= '0;
      blocks_done  <= '0;
      aborted      <= 1'b0;
      rr_ptr       <= '0;
      run_q        <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        bid_q[i] <= '0;
        ct_q[i]  <= CTW'(THREADS_PER_BLOCK);
      end
    end else begin
      if (state == S_IDLE && start) begin
        tc_q         <= thread_count;
        total_blocks <= launch_blocks;
        dispatched   <= '0;
        blocks_done  <= '0;
        aborted      <= 1'b0;
      end
      if (state == S_RUN || state == S_DRAIN) blocks_done <= bd_next[TC_WIDTH-1:0];
      if (state == S_RUN && abort) aborted <= 1'b1;
      if (grant_fire) begin
        dispatched <= dispatched + CW'(1);
        rr_ptr     <= rr_next;
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (completing[i]) begin
          run_q[i] <= 1'b0;
        end else if (grant_fire && grant_idx == PW'(i)) begin
          run_q[i] <= 1'b1;
          bid_q[i] <= BID_WIDTH'(dispatched);
          ct_q[i]  <= grant_ct;
        end
      end
    end
  end

  assign core_start = run_q;
  assign core_reset = ~run_q;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_out
    assign core_block_id[g*BID_WIDTH +: BID_WIDTH] = bid_q[g];
    assign core_thread_count[g*CTW +: CTW]         = ct_q[g];
  end

endmodule

// File: tb/tb_block_scheduler.sv
// tb/tb_block_scheduler.sv - randomized self-checking bench for block_scheduler
`timescale 1ns/100ps
module tb_block_scheduler;

  localparam int NC   = 4;
  localparam int TPB  = 4;
  localparam int TCW  = 16;
  localparam int BIDW = 16;
  localparam int CTW  = $clog2(TPB) + 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort;
  logic [TCW-1:0]    thread_count;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_start, core_reset;
  logic [NC*BIDW-1:0] core_block_id;
  logic [NC*CTW-1:0] core_thread_count;
  logic              busy, done, aborted;
  logic [TCW-1:0]    blocks_done;

  int checks = 0;
  int failures = 0;

  // Reference model: which block each core holds, round-robin pointer, counters.
  int            m_state, m_tc, m_total, m_disp, m_bd, m_rr;
  logic          m_aborted;
  logic [NC-1:0] m_run;
  int            m_bid [NC];
  int            m_ct  [NC];
  int            issued [64];
  logic [NC-1:0] prev_cs;

  block_scheduler #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .TC_WIDTH(TCW), .BID_WIDTH(BIDW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .thread_count(thread_count),
    .core_done(core_done), .core_start(core_start), .core_reset(core_reset),
    .core_block_id(core_block_id), .core_thread_count(core_thread_count),
    .busy(busy), .done(done), .aborted(aborted), .blocks_done(blocks_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_tc = 0; m_total = 0; m_disp = 0; m_bd = 0; m_rr = 0;
    m_aborted = 1'b0; m_run = '0; prev_cs = '0;
    for (int i = 0; i < NC; i++) begin m_bid[i] = 0; m_ct[i] = TPB; end
  endtask

  task automatic model_edge(input logic s, input logic a, input logic [NC-1:0] dv, input int tcin);
    logic [NC-1:0] comp;
    int g, c, rem;
    comp = dv & m_run;
    g = -1;
    case (m_state)
      M_IDLE: if (s) begin
        m_state = M_RUN; m_tc = tcin; m_total = (tcin + TPB - 1) / TPB;
        m_bd = 0; m_disp = 0; m_aborted = 1'b0;
      end
      M_RUN: begin
        if (m_disp < m_total && !a)
          for (int k = 0; k < NC; k++) begin
            c = (m_rr + k) % NC;
            if (g < 0 && !m_run[c]) g = c;
          end
        m_bd += $countones(comp);
        m_run &= ~comp;
        if (g >= 0) begin
          rem = m_tc - m_disp * TPB;
          m_run[g] = 1'b1; m_bid[g] = m_disp; m_ct[g] = (rem > TPB) ? TPB : rem;
          m_disp++; m_rr = (g + 1) % NC;
        end
        if (a) begin m_state = M_DRAIN; m_aborted = 1'b1; end
        else if (m_bd >= m_total) m_state = M_DONE;
      end
      M_DRAIN: begin
        m_bd += $countones(comp);
        m_run &= ~comp;
        if (m_run == '0) m_state = M_DONE;
      end
      default: if (!s) m_state = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    logic [NC-1:0] nr;
    nr = ~m_run;
    chk("core_start", 32'(core_start), 32'(m_run));
    chk("core_reset", 32'(core_reset), 32'(nr));
    chk("busy", 32'(busy), 32'(m_state == M_RUN || m_state == M_DRAIN));
    chk("done", 32'(done), 32'(m_state == M_DONE));
    chk("aborted", 32'(aborted), 32'(m_aborted));
    chk("blocks_done", 32'(blocks_done), m_bd);
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("block_id%0d", i), 32'(core_block_id[i*BIDW +: BIDW]), m_bid[i]);
      chk($sformatf("thread_cnt%0d", i), 32'(core_thread_count[i*CTW +: CTW]), m_ct[i]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(core_start), 0);
    chk({tag, "_reset"}, 32'(core_reset), (1 << NC) - 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
    chk({tag, "_bd"}, 32'(blocks_done), 0);
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("%s_bid%0d", tag, i), 32'(core_block_id[i*BIDW +: BIDW]), 0);
      chk($sformatf("%s_ct%0d", tag, i), 32'(core_thread_count[i*CTW +: CTW]), TPB);
    end
  endtask

  task automatic step();
    logic s, a;
    logic [NC-1:0] dv;
    int t;
    s = start; a = abort; dv = core_done; t = int'(thread_count);
    @(posedge clk);
    model_edge(s, a, dv, t);
    #1;
    compare_all();
    for (int i = 0; i < NC; i++)
      if (core_start[i] && !prev_cs[i] && core_block_id[i*BIDW +: BIDW] < 64)
        issued[core_block_id[i*BIDW +: BIDW]]++;
    prev_cs = core_start;
  endtask

  task automatic run_kernel(input int tc, input int abort_at, input int prob);
    int cyc, p;
    thread_count = TCW'(tc); start = 1'b1; abort = 1'b0; core_done = '0;
    step();
    cyc = 0;
    while (m_state != M_DONE && cyc < 2000) begin
      if (abort_at >= 0 && m_disp >= abort_at) abort = 1'b1;
      p = (abort_at >= 0 && !abort) ? 0 : prob;
      for (int i = 0; i < NC; i++)
        core_done[i] = m_run[i] ? ($urandom_range(0, 99) < p) : ($urandom_range(0, 9) == 0);
      thread_count = TCW'($urandom);
      step();
      cyc++;
    end
    chk("kernel_timeout", 32'(cyc < 2000), 1);
    core_done = '0; abort = 1'b0; start = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; thread_count = '0; core_done = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;

    // thread_count=8: two blocks on consecutive cycles, simultaneous completion
    start = 1'b1; thread_count = 16'd8;
    step();
    step();
    chk("t8_first_grant", 32'(core_start), 32'b0001);
    step();
    chk("t8_second_grant", 32'(core_start), 32'b0011);
    step();
    core_done = 4'b0011;
    step();
    chk("t8_blocks_done", 32'(blocks_done), 2);
    chk("t8_done", 32'(done), 1);
    core_done = '0; start = 1'b0;
    step();
    chk("t8_idle_done", 32'(done), 0);

    // thread_count=10: partial last block
    run_kernel(10, -1, 30);
    chk("t10_blocks_done", 32'(blocks_done), 3);
    chk("t10_aborted", 32'(aborted), 0);

    // thread_count=0: straight to DONE, no core ever started
    start = 1'b1; thread_count = '0;
    step();
    chk("t0_busy", 32'(busy), 1);
    step();
    chk("t0_done", 32'(done), 1);
    chk("t0_no_start", 32'(core_start), 0);
    start = 1'b0;
    step();
    chk("t0_idle_done", 32'(done), 0);

    // 64 threads: every block id issued exactly once
    for (int b = 0; b < 64; b++) issued[b] = 0;
    run_kernel(64, -1, 35);
    chk("t64_blocks_done", 32'(blocks_done), 16);
    for (int b = 0; b < 16; b++) chk($sformatf("t64_issued%0d", b), issued[b], 1);

    // abort after three dispatches of eight blocks
    run_kernel(32, 3, 30);
    chk("abort_blocks_done", 32'(blocks_done), 3);
    chk("abort_aborted", 32'(aborted), 1);

    // asynchronous reset pulse between clock edges mid-kernel
    start = 1'b1; thread_count = 16'd40;
    repeat (6) begin
      for (int i = 0; i < NC; i++) core_done[i] = m_run[i] && ($urandom_range(0, 99) < 25);
      step();
    end
    #3;
    reset = 1'b0;
    #0.5;
    check_reset_vals("mid_reset");
    model_reset();
    start = 1'b0; core_done = '0;
    #0.5;
    reset = 1'b1;
    step();
    run_kernel(12, -1, 40);
    chk("post_reset_blocks_done", 32'(blocks_done), 3);

    // a few random kernels back to back
    repeat (4) run_kernel(int'($urandom_range(0, 50)), -1, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_scheduler.md
Name: block_scheduler

Overview:
Top-level kernel block scheduler, the parametrised successor to the single-kernel dispatcher. It splits a kernel's thread_count into fixed-size blocks and hands them to NUM_CORES compute cores through a per-core reset/start/done handshake. It adds round-robin core selection, wider thread counts, multiple simultaneous completions, and graceful abort. It sits at GPU top level between the device control register and the cores.

Parameters:
NUM_CORES, 2, number of compute cores served (1..16)
THREADS_PER_BLOCK, 4, threads per block; power of two, 1..256
TC_WIDTH, 16, width of thread_count and derived block counters
BID_WIDTH, 16, width of core_block_id; must be >= TC_WIDTH - log2(THREADS_PER_BLOCK)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  kernel launch level; accepted in IDLE when high
abort  in  1  level; stop dispatching, drain in-flight blocks
thread_count  in  TC_WIDTH  total kernel threads; sampled at launch
core_done  in  NUM_CORES  per-core block-complete level
core_start  out  NUM_CORES  per-core run request, held until done
core_reset  out  NUM_CORES  per-core reset
core_block_id  out  NUM_CORES x BID_WIDTH  block index for each core
core_thread_count  out  NUM_CORES x (log2(THREADS_PER_BLOCK)+1)  live threads in the assigned block
busy  out  1  high in RUN or DRAIN
done  out  1  kernel finished; held until start low
aborted  out  1  qualifies done; last kernel ended by abort
blocks_done  out  TC_WIDTH  count of completed blocks for the current kernel

Behaviour:
- Reset (reset=0, async): top FSM=IDLE; core_start=0; core_reset=all 1s; core_block_id=0; core_thread_count=THREADS_PER_BLOCK; busy=0; done=0; aborted=0; blocks_done=0; dispatched=0; round-robin pointer=0.
- Top FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE->RUN when start=1. Latch thread_count as tc_q. total_blocks = (tc_q + THREADS_PER_BLOCK-1) >> log2(THREADS_PER_BLOCK), computed at TC_WIDTH+1 bits with no overflow. Clear blocks_done, dispatched, aborted.
- If tc_q=0: RUN->DONE on the next cycle with no core started.
- Per-core states are PARK (core_reset=1, core_start=0), RUN (core_reset=0, core_start=1).
- In RUN, at most one block is dispatched per cycle. The granted core is the first PARK core at or after the RR pointer, wrapping. This applies only while dispatched < total_blocks and abort=0.
- Grant effects (all registered, visible next cycle):
  - core_reset[i]=0, core_start[i]=1, core_block_id[i]=dispatched.
  - core_thread_count[i]=THREADS_PER_BLOCK, except the last block, which gets tc_q - dispatched*THREADS_PER_BLOCK (range 1..THREADS_PER_BLOCK).
  - dispatched+1; RR pointer = i+1 mod NUM_CORES.
- A core in RUN with core_done=1 returns to PARK next cycle: core_start=0, core_reset=1. The core may be re-granted no earlier than the cycle after that.
- Several cores may complete in the same cycle. blocks_done increases by the popcount of completing cores.
- Completion and grant for different cores may occur in the same cycle. A core completing this cycle is not grantable this cycle.
- RUN->DONE when blocks_done (including this cycle's completions) reaches total_blocks.
- abort=1 in RUN: go to DRAIN, stop granting, set aborted=1. In-flight cores finish normally.
- DRAIN->DONE when no core is in RUN. abort is ignored in IDLE and DONE.
- DONE: done=1, busy=0, all cores PARK. DONE->IDLE when start=0; done, but not aborted, clears on entry to IDLE.
- core_done for a PARK core is ignored.
- start or thread_count changes during RUN or DRAIN are ignored.
- Reset asserted mid-kernel: immediate return to reset values. No completions are counted.

Test Plan:
- NUM_CORES=2, TPB=4, thread_count=8 -> blocks 0,1 granted on consecutive cycles with core_thread_count 4,4. Both core_done raised together -> blocks_done jumps 0->2, done=1 next cycle.
- thread_count=10, TPB=4, NUM_CORES=2 -> block 2 granted to the first freed core with core_thread_count=2; blocks_done=3; done=1, aborted=0.
- thread_count=0 -> no core_start ever; done=1 two cycles after start; start low -> IDLE, done=0.
- NUM_CORES=4, thread_count=64, TPB=4, cores finish in random order -> block IDs 0..15 each issued exactly once; RR grant order holds; blocks_done=16.
- Abort after 3 of 8 blocks dispatched -> no further grants; done=1 and aborted=1 after the last in-flight core_done; blocks_done=3.
- reset pulled low for 1 ns mid-RUN, between clock edges -> all outputs at reset values immediately. A new launch after reset releases works normally.
